// File: rtl/branch_redirect_ctrl_if.sv
// Branch redirect bus: ALU result in, fetch redirect handshake, issue/flush
// control, predictor update and statistics out.
interface branch_redirect_ctrl_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
);
  logic             br_valid;
  logic             br_req;
  logic [XLEN-1:0]  br_jmp;
  logic [XLEN-1:0]  br_pc;
  logic             br_mispredict;
  logic             br_error;
  logic             br_clear;
  logic             stall_issue;
  logic             flush;
  logic             redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic             redirect_ready;
  logic             pred_upd_valid;
  logic [XLEN-1:0]  pred_upd_pc;
  logic             pred_upd_taken;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  // ALU / fetch side
  modport master (
    output br_valid, br_req, br_jmp, br_pc, br_mispredict, br_error, redirect_ready,
    input  br_clear, stall_issue, flush, redirect_valid, redirect_pc,
           pred_upd_valid, pred_upd_pc, pred_upd_taken, branch_cnt, mispred_cnt
  );

  // controller side
  modport slave (
    input  br_valid, br_req, br_jmp, br_pc, br_mispredict, br_error, redirect_ready,
    output br_clear, stall_issue, flush, redirect_valid, redirect_pc,
           pred_upd_valid, pred_upd_pc, pred_upd_taken, branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Branch redirect controller: latches a resolved branch, flushes the wrong
// path, hands a redirect PC to fetch and releases the ALU result.
//
// state      | meaning
// -----------+---------------------------------------------------------
// S_IDLE     | waiting for a branch result (or 1-cycle bubble on a hit)
// S_FLUSH    | flush held for FLUSH_CYCLES cycles (down-counter)
// S_REDIRECT | redirect_valid held until fetch accepts
// S_RESUME   | br_clear pulse, issue resumes next cycle
module branch_redirect_ctrl #(
  parameter int unsigned     XLEN         = 32,
  parameter int unsigned     IF_INC       = 4,
  parameter int unsigned     FLUSH_CYCLES = 2,
  parameter logic [XLEN-1:0] TRAP_VEC     = XLEN'('h100),
  parameter int unsigned     CNT_W        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  branch_redirect_ctrl_if.slave io_bus
);

  localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FLUSH, S_REDIRECT, S_RESUME} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [FCW-1:0]   r_flush_cnt;
  logic [XLEN-1:0]  r_target;
  logic             r_bubble;
  logic             r_pred_valid;
  logic [XLEN-1:0]  r_pred_pc;
  logic             r_pred_taken;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;
  logic             w_capture;
  logic             w_err;
  logic             w_mis;
  logic             w_ok;

  // next state; a result is captured only in IDLE and not during the hit bubble
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (io_bus.br_valid && !r_bubble) begin
          w_capture = 1'b1;
          if (io_bus.br_error || io_bus.br_mispredict) w_state_nxt = S_FLUSH;
        end
      end
      S_FLUSH:    if (r_flush_cnt == '0) w_state_nxt = S_REDIRECT;
      S_REDIRECT: if (io_bus.redirect_ready) w_state_nxt = S_RESUME;
      S_RESUME:   w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  assign w_err = w_capture & io_bus.br_error;
  assign w_mis = w_capture & ~io_bus.br_error & io_bus.br_mispredict;
  assign w_ok  = w_capture & ~io_bus.br_error & ~io_bus.br_mispredict;

  // state register
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // flush timer, redirect target, predictor update and statistics
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_flush_cnt   <= '0;
      r_target      <= '0;
      r_bubble      <= 1'b0;
      r_pred_valid  <= 1'b0;
      r_pred_pc     <= '0;
      r_pred_taken  <= 1'b0;
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
    end else begin
      r_bubble     <= w_ok;
      r_pred_valid <= w_ok | w_mis;
      if (w_err || w_mis) r_flush_cnt <= FCW'(FLUSH_CYCLES - 1);
      else if (r_state == S_FLUSH && r_flush_cnt != '0) r_flush_cnt <= r_flush_cnt - FCW'(1);
      if (w_err) r_target <= TRAP_VEC;
      else if (w_mis) r_target <= io_bus.br_req ? io_bus.br_jmp : io_bus.br_pc + XLEN'(IF_INC);
      if (w_ok || w_mis) begin
        r_pred_pc    <= io_bus.br_pc;
        r_pred_taken <= io_bus.br_req;
      end
      if ((w_ok || w_mis) && r_branch_cnt != {CNT_W{1'b1}})
        r_branch_cnt <= r_branch_cnt + CNT_W'(1);
      if ((w_err || w_mis) && r_mispred_cnt != {CNT_W{1'b1}})
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
    end
  end

  assign io_bus.br_clear       = r_bubble | (r_state == S_RESUME);
  assign io_bus.stall_issue    = r_bubble | (r_state != S_IDLE);
  assign io_bus.flush          = (r_state == S_FLUSH);
  assign io_bus.redirect_valid = (r_state == S_REDIRECT);
  assign io_bus.redirect_pc    = (r_state == S_REDIRECT) ? r_target : '0;
  assign io_bus.pred_upd_valid = r_pred_valid;
  assign io_bus.pred_upd_pc    = r_pred_pc;
  assign io_bus.pred_upd_taken = r_pred_taken;
  assign io_bus.branch_cnt     = r_branch_cnt;
  assign io_bus.mispred_cnt    = r_mispred_cnt;

endmodule
